// File: rtl/dm_arbiter.sv
// dm_arbiter: round-robin arbiter between two requesters onto a word-only data memory, with read-modify-write byte-enable stores.
// Optional `DM_ARB_TRACE_EN` prints every committed DM write.
module dm_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [3:0]        be0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  input  logic              req1,
  input  logic              we1,
  input  logic [3:0]        be1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        gnt,
  output logic              busy,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wd,
  output logic              dm_we,
  input  logic [DATA_W-1:0] dm_rd
);
  typedef enum logic [1:0] {IDLE, ACCESS, MERGE, DONE} state_t;
  state_t            state_q;
  logic              last_q, we_q, ack0_q, ack1_q;
  logic [1:0]        gnt_q;
  logic [3:0]        be_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, merged_q, rdata_q, merged_d;
  logic              pick1, full, none, partial;
  always_comb begin
    // port 1 wins when alone, or on a tie when port 0 was served last
    pick1 = req1 & (~req0 | ~last_q);
    full = &be_q;
    none = ~|be_q;
    partial = we_q & ~full & ~none;
    merged_d = dm_rd;
    for (int i = 0; i < 4; i++)
      merged_d[8*i +: 8] = be_q[i] ? wdata_q[8*i +: 8] : dm_rd[8*i +: 8];
  end
  assign dm_we = (state_q == ACCESS && we_q && full) || state_q == MERGE;
  assign dm_wd = state_q == MERGE ? merged_q : wdata_q;
  assign dm_addr = addr_q & ~ADDR_W'(3);
  assign busy = state_q != IDLE;
  assign gnt = gnt_q;
  assign ack0 = ack0_q;
  assign ack1 = ack1_q;
  assign rdata = rdata_q;
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      gnt_q    <= 2'b00;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      we_q     <= 1'b0;
      be_q     <= 4'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      merged_q <= '0;
      rdata_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (req0 | req1) begin
          we_q    <= pick1 ? we1 : we0;
          be_q    <= pick1 ? be1 : be0;
          addr_q  <= pick1 ? addr1 : addr0;
          wdata_q <= pick1 ? wdata1 : wdata0;
          gnt_q   <= pick1 ? 2'b10 : 2'b01;
          last_q  <= pick1;
          state_q <= ACCESS;
        end
        ACCESS: begin
          if (!we_q) rdata_q <= dm_rd;
          merged_q <= merged_d;
          ack0_q   <= gnt_q[0] & ~partial;
          ack1_q   <= gnt_q[1] & ~partial;
          state_q  <= partial ? MERGE : DONE;
        end
        MERGE: begin
          ack0_q  <= gnt_q[0];
          ack1_q  <= gnt_q[1];
          state_q <= DONE;
        end
        default: begin
          ack0_q  <= 1'b0;
          ack1_q  <= 1'b0;
          gnt_q   <= 2'b00;
          state_q <= IDLE;
        end
      endcase
    end
  end
`ifdef DM_ARB_TRACE_EN
  always @(posedge CLK)
    if (dm_we && !Reset) $display("P%0d: *%h <= %h", gnt_q[1], dm_addr, dm_wd);
`endif
endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: directed checks of dm_arbiter against a small behavioural data memory.
module tb_dm_arbiter;
  logic        CLK = 0, Reset = 1;
  logic        req0 = 0, we0 = 0, req1 = 0, we1 = 0;
  logic [3:0]  be0 = 0, be1 = 0;
  logic [31:0] addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0;
  logic        ack0, ack1, busy, dm_we;
  logic [1:0]  gnt;
  logic [31:0] rdata, dm_addr, dm_wd, dm_rd;
  logic [31:0] mem [0:63];
  int total = 0, bad = 0;
  int we_cnt = 0, ack0_cnt = 0, ack1_cnt = 0;
  logic [31:0] last_wa, last_wd;

  dm_arbiter dut (
    .CLK(CLK), .Reset(Reset),
    .req0(req0), .we0(we0), .be0(be0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0),
    .req1(req1), .we1(we1), .be1(be1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1),
    .rdata(rdata), .gnt(gnt), .busy(busy),
    .dm_addr(dm_addr), .dm_wd(dm_wd), .dm_we(dm_we), .dm_rd(dm_rd)
  );

  always #5 CLK = ~CLK;
  assign dm_rd = mem[dm_addr[7:2]];
  always @(posedge CLK) begin
    if (dm_we) begin
      mem[dm_addr[7:2]] <= dm_wd;
      we_cnt <= we_cnt + 1;
      last_wa <= dm_addr;
      last_wd <= dm_wd;
    end
    if (ack0) ack0_cnt <= ack0_cnt + 1;
    if (ack1) ack1_cnt <= ack1_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // issue one request, hold until its ack, return edge count from sample edge to ack and first-cycle grant
  task automatic xfer(input int p, input logic w, input logic [3:0] b, input logic [31:0] a,
                      input logic [31:0] d, output int lat, output logic [1:0] g);
    lat = 0;
    g = 2'b00;
    if (p == 0) begin req0 = 1; we0 = w; be0 = b; addr0 = a; wdata0 = d; end
    else        begin req1 = 1; we1 = w; be1 = b; addr1 = a; wdata1 = d; end
    for (int n = 1; n <= 10; n++) begin
      tick();
      if (n == 1) g = gnt;
      if ((p == 0 && ack0) || (p == 1 && ack1)) begin lat = n; break; end
    end
    if (lat == 0) check("ack_timeout", 32'd0, 32'd1);
    req0 = 0;
    req1 = 0;
    tick();
  endtask

  int lat, w0, a0, a1;
  logic [1:0] g;
  int ord [4];
  int n;
  logic pend0, pend1;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[4] = 32'hDEADBEEF;
    mem[8] = 32'h11223344;
    tick();
    check("rst_gnt", {30'd0, gnt}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ack", {30'd0, ack1, ack0}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_dm_addr", dm_addr, 32'd0);
    check("rst_dm_wd", dm_wd, 32'd0);
    Reset = 0;
    tick();

    // port 0 read
    w0 = we_cnt;
    xfer(0, 0, 4'b0000, 32'h10, 32'h0, lat, g);
    check("rd_gnt", {30'd0, g}, 32'd1);
    check("rd_lat", lat, 2);
    check("rd_data", rdata, 32'hDEADBEEF);
    check("rd_no_we", we_cnt - w0, 0);

    // port 1 partial write
    w0 = we_cnt;
    a0 = ack0_cnt;
    xfer(1, 1, 4'b0010, 32'h22, 32'h0000AB00, lat, g);
    check("pw_gnt", {30'd0, g}, 32'd2);
    check("pw_lat", lat, 3);
    check("pw_we_cnt", we_cnt - w0, 1);
    check("pw_addr", last_wa, 32'h20);
    check("pw_data", last_wd, 32'h1122AB44);
    check("pw_mem", mem[8], 32'h1122AB44);
    check("pw_no_ack0", ack0_cnt - a0, 0);

    // port 0 empty write
    w0 = we_cnt;
    xfer(0, 1, 4'b0000, 32'h10, 32'hFFFFFFFF, lat, g);
    check("ew_lat", lat, 2);
    check("ew_no_we", we_cnt - w0, 0);
    check("ew_mem", mem[4], 32'hDEADBEEF);

    // full write then unaligned read of the same word
    xfer(0, 1, 4'b1111, 32'h40, 32'hCAFEF00D, lat, g);
    check("fw_lat", lat, 2);
    check("fw_mem", mem[16], 32'hCAFEF00D);
    xfer(0, 0, 4'b0000, 32'h43, 32'h0, lat, g);
    check("fw_rdback", rdata, 32'hCAFEF00D);

    // reset during MERGE aborts the write
    a0 = ack0_cnt;
    req0 = 1; we0 = 1; be0 = 4'b1000; addr0 = 32'h40; wdata0 = 32'hAA000000;
    tick();
    tick();
    check("mg_we_before", {31'd0, dm_we}, 32'd1);
    Reset = 1;
    #1;
    check("mg_we_drop", {31'd0, dm_we}, 32'd0);
    check("mg_busy_drop", {31'd0, busy}, 32'd0);
    req0 = 0;
    tick();
    tick();
    Reset = 0;
    tick();
    check("mg_no_ack", ack0_cnt - a0, 0);
    check("mg_mem", mem[16], 32'hCAFEF00D);
    xfer(0, 0, 4'b0000, 32'h40, 32'h0, lat, g);
    check("mg_after_lat", lat, 2);
    check("mg_after_rd", rdata, 32'hCAFEF00D);

    // both ports requesting from reset alternate
    Reset = 1;
    tick();
    Reset = 0;
    a0 = ack0_cnt;
    a1 = ack1_cnt;
    req0 = 1; we0 = 0; addr0 = 32'h10;
    req1 = 1; we1 = 0; addr1 = 32'h20;
    n = 0;
    pend0 = 0;
    pend1 = 0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      tick();
      if (ack0) begin ord[n] = 0; n++; req0 = 0; pend0 = 1; end
      else if (pend0) begin req0 = 1; pend0 = 0; end
      if (ack1) begin ord[n] = 1; n++; req1 = 0; pend1 = 1; end
      else if (pend1) begin req1 = 1; pend1 = 0; end
    end
    req0 = 0;
    req1 = 0;
    tick();
    tick();
    check("rr_count", n, 4);
    if (n == 4) begin
      check("rr_0", ord[0], 0);
      check("rr_1", ord[1], 1);
      check("rr_2", ord[2], 0);
      check("rr_3", ord[3], 1);
    end
    check("rr_ack0", ack0_cnt - a0, 2);
    check("rr_ack1", ack1_cnt - a1, 2);
    check("rr_idle", {31'd0, busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
